// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared constants for the MEM-to-WB stage
package mem_wb_stage_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'hbfc00000;

    localparam logic [4:0] EXC_NONE = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;

    // mem_op[2] selects store, mem_op[1:0] selects access size
    localparam int MEM_OP_STORE_BIT = 2;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_e;

endpackage

// File: rtl/mem_align_unit.sv
// rtl/mem_align_unit.sv - misalign detection, byte enables and store-data replication (MEM_ALIGN_CHECK_EN)
module mem_align_unit
    import mem_wb_stage_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        store,
    input  logic [31:0] rt_data,
    output logic        misalign,
    output logic [3:0]  wen,
    output logic [31:0] wdata
);

    logic        misalign_raw;
    logic [3:0]  wen_raw;

    always_comb begin
        misalign_raw = 1'b0;
        wen_raw      = 4'b1111;
        wdata        = rt_data;
        case (size)
            SIZE_BYTE: begin
                wen_raw = 4'b0001 << addr_lo;
                wdata   = {4{rt_data[7:0]}};
            end
            SIZE_HALF: begin
                misalign_raw = addr_lo[0];
                // addr_lo[0] is ignored so an unchecked misaligned half lands on its containing halfword
                wen_raw      = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata        = {2{rt_data[15:0]}};
            end
            default: begin
                misalign_raw = (addr_lo != 2'b00);
                wen_raw      = 4'b1111;
                wdata        = rt_data;
            end
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = misalign_raw;
`else
    assign misalign = misalign_raw & 1'b0;
`endif

    assign wen = store ? wen_raw : 4'b0000;

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM-to-WB pipeline register with alignment exceptions and SRAM gating (MEM_ALIGN_CHECK_EN)
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        mem_allow_in,
    input  logic [31:0] ex_pc,
    input  logic        ex_bd,
    input  logic        ex_exception,
    input  logic [4:0]  ex_ExcCode,
    input  logic [31:0] ex_bad_vaddr,
    input  logic        ex_eret,
    input  logic [1:0]  ex_mftc0_op,
    input  logic [7:0]  ex_cp0_addr,
    input  logic [31:0] ex_rt_data,
    input  logic [31:0] ex_mem_addr,
    input  logic [2:0]  ex_mem_op,
    input  logic        ex_mem_en,
    input  logic        wb_allow_in,
    input  logic        ClrStpJmp,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    output logic        valid_r,
    output logic        mem_to_wb_exception_r,
    output logic        mem_to_wb_bd_r,
    output logic        mem_to_wb_eret_r,
    output logic [4:0]  mem_to_wb_ExcCode_r,
    output logic [7:0]  mem_to_wb_cp0_addr_r,
    output logic [1:0]  mem_to_wb_mftc0_op_r,
    output logic [31:0] mem_to_wb_mtc0_data_r,
    output logic [31:0] mem_to_wb_PC_r,
    output logic [31:0] mem_to_wb_error_VAddr_r
);

    logic        transfer;
    logic        is_store;
    logic        misalign;
    logic        new_exc;
    logic        wb_blocks;
    logic [3:0]  align_wen;
    logic [31:0] align_wdata;
    logic        nxt_exception;
    logic [4:0]  nxt_code;
    logic [31:0] nxt_vaddr;

    assign mem_allow_in = !valid_r | wb_allow_in;
    assign transfer     = ex_valid & mem_allow_in;
    assign is_store     = ex_mem_op[MEM_OP_STORE_BIT];

    mem_align_unit u_align (
        .addr_lo  (ex_mem_addr[1:0]),
        .size     (ex_mem_op[1:0]),
        .store    (is_store),
        .rt_data  (ex_rt_data),
        .misalign (misalign),
        .wen      (align_wen),
        .wdata    (align_wdata)
    );

    assign new_exc = ex_mem_en & misalign;

    // An excepting or ERET bundle already in WB means everything in MEM is younger and about to be flushed
    assign wb_blocks = valid_r & (mem_to_wb_exception_r | mem_to_wb_eret_r);

    assign data_sram_en    = rst_n & transfer & ex_mem_en & !ex_exception & !new_exc
                           & !ClrStpJmp & !wb_blocks;
    assign data_sram_wen   = data_sram_en ? align_wen : 4'b0000;
    assign data_sram_addr  = rst_n ? {ex_mem_addr[31:2], 2'b00} : 32'h0;
    assign data_sram_wdata = rst_n ? align_wdata : 32'h0;

    always_comb begin
        nxt_exception = ex_exception | new_exc;
        nxt_code      = EXC_NONE;
        nxt_vaddr     = 32'h0;
        if (ex_exception) begin
            nxt_code  = ex_ExcCode;
            nxt_vaddr = ex_bad_vaddr;
        end else if (new_exc) begin
            nxt_code  = is_store ? EXC_ADES : EXC_ADEL;
            nxt_vaddr = ex_mem_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r                 <= 1'b0;
            mem_to_wb_exception_r   <= 1'b0;
            mem_to_wb_bd_r          <= 1'b0;
            mem_to_wb_eret_r        <= 1'b0;
            mem_to_wb_ExcCode_r     <= EXC_NONE;
            mem_to_wb_cp0_addr_r    <= 8'h0;
            mem_to_wb_mftc0_op_r    <= 2'b00;
            mem_to_wb_mtc0_data_r   <= 32'h0;
            mem_to_wb_PC_r          <= PC_RESET;
            mem_to_wb_error_VAddr_r <= 32'h0;
        end else begin
            if (ClrStpJmp) begin
                valid_r <= 1'b0;
            end else if (mem_allow_in) begin
                valid_r <= ex_valid;
            end
            if (transfer) begin
                mem_to_wb_exception_r   <= nxt_exception;
                mem_to_wb_bd_r          <= ex_bd;
                mem_to_wb_eret_r        <= ex_eret;
                mem_to_wb_ExcCode_r     <= nxt_code;
                mem_to_wb_cp0_addr_r    <= ex_cp0_addr;
                mem_to_wb_mftc0_op_r    <= ex_mftc0_op;
                mem_to_wb_mtc0_data_r   <= ex_rt_data;
                mem_to_wb_PC_r          <= ex_pc;
                mem_to_wb_error_VAddr_r <= nxt_vaddr;
            end
        end
    end

endmodule
